// File: rtl/n64adv_vout_timing_monitor_pkg.sv
// n64adv_vout_timing_monitor_pkg: shared sync bit map, lock FSM encoding and helpers
package n64adv_vout_timing_monitor_pkg;
  localparam int SY_VS = 3;
  localparam int SY_BL = 2;
  localparam int SY_HS = 1;
  localparam int SY_CS = 0;
  localparam int UCNT_W = 8;
  typedef enum logic [1:0] {SEARCH, ALIGNED, CHECK, LOCKED} lock_state_t;
  function automatic logic [UCNT_W-1:0] sat_inc_ucnt(input logic [UCNT_W-1:0] x);
    return &x ? x : x + UCNT_W'(1);
  endfunction
endpackage

// File: rtl/n64adv_vout_timing_monitor_timing_lock_fsm.sv
// n64adv_vout_timing_monitor_timing_lock_fsm: judges frame-to-frame timing stability and tracks lock losses
module n64adv_vout_timing_monitor_timing_lock_fsm
  import n64adv_vout_timing_monitor_pkg::*;
#(
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 11,
  parameter int STABLE_FRAMES = 4,
  parameter int VTOL = 1
) (
  input  logic              VCLK,
  input  logic              nVRST_Tx,
  input  logic              clr,
  input  logic              vs_edge,
  input  logic              watchdog,
  input  logic [HCNT_W-1:0] m_h,
  input  logic [VCNT_W-1:0] m_v,
  output logic              timing_stable_o,
  output logic [UCNT_W-1:0] unstable_cnt_o
);
  localparam logic signed [VCNT_W:0] TOL = (VCNT_W+1)'(VTOL);
  localparam logic [3:0] LOCK_AT = 4'(STABLE_FRAMES - 1);
  lock_state_t state;
  logic [HCNT_W-1:0] ref_h;
  logic [VCNT_W-1:0] ref_v;
  logic [3:0] match_cnt;
  logic signed [VCNT_W:0] dv;
  logic match;
  // line-count tolerance absorbs the odd/even field alternation; h must match exactly
  always_comb begin
    dv = $signed({1'b0, m_v}) - $signed({1'b0, ref_v});
    match = (m_h == ref_h) && (dv <= TOL) && (dv >= -TOL);
  end
  // lock progression: align on a partial frame, take a reference, then count matching frames
  always_ff @(posedge VCLK or negedge nVRST_Tx)
    if (!nVRST_Tx) begin
      state <= SEARCH;
      ref_h <= '0;
      ref_v <= '0;
      match_cnt <= '0;
      timing_stable_o <= 1'b0;
      unstable_cnt_o <= '0;
    end else if (clr) begin
      state <= SEARCH;
      ref_h <= '0;
      ref_v <= '0;
      match_cnt <= '0;
      timing_stable_o <= 1'b0;
      unstable_cnt_o <= '0;
    end else if (watchdog) begin
      state <= SEARCH;
      timing_stable_o <= 1'b0;
      match_cnt <= '0;
      if (state == LOCKED) unstable_cnt_o <= sat_inc_ucnt(unstable_cnt_o);
    end else if (vs_edge) begin
      if (state == SEARCH) state <= ALIGNED;
      else if (state == ALIGNED || !match) begin
        ref_h <= m_h;
        ref_v <= m_v;
        match_cnt <= '0;
        state <= CHECK;
        timing_stable_o <= 1'b0;
        if (state != ALIGNED) unstable_cnt_o <= sat_inc_ucnt(unstable_cnt_o);
      end else if (state == CHECK) begin
        match_cnt <= match_cnt + 4'd1;
        if (match_cnt + 4'd1 == LOCK_AT) begin
          state <= LOCKED;
          timing_stable_o <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/n64adv_vout_timing_monitor.sv
// n64adv_vout_timing_monitor: passive measurement of output line/frame timing with stability lock
module n64adv_vout_timing_monitor
  import n64adv_vout_timing_monitor_pkg::*;
#(
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 11,
  parameter int STABLE_FRAMES = 4,
  parameter int VTOL = 1
) (
  input  logic              VCLK,
  input  logic              nVRST_Tx,
  input  logic              clr_i,
  input  logic              vdata_valid_i,
  input  logic [3:0]        sync_i,
  output logic [HCNT_W-1:0] h_total_o,
  output logic [HCNT_W-1:0] h_active_o,
  output logic [VCNT_W-1:0] v_total_o,
  output logic              frame_strobe_o,
  output logic              timing_stable_o,
  output logic [UCNT_W-1:0] unstable_cnt_o
);
  logic [3:0] prev_sync;
  logic [HCNT_W-1:0] hcnt, acnt, hcnt_n, acnt_n, m_h;
  logic [VCNT_W-1:0] vcnt, vcnt_n;
  logic hs_edge, vs_edge, watchdog;
  logic unused_sync;
  assign unused_sync = ^{sync_i[SY_CS], prev_sync[SY_BL], prev_sync[SY_CS]};
  // edge detection between valid samples and next counter values; a coincident HS opens the new frame
  always_comb begin
    hs_edge = vdata_valid_i & prev_sync[SY_HS] & ~sync_i[SY_HS];
    vs_edge = vdata_valid_i & prev_sync[SY_VS] & ~sync_i[SY_VS];
    hcnt_n = hs_edge ? HCNT_W'(1) : &hcnt ? hcnt : hcnt + HCNT_W'(1);
    acnt_n = hs_edge ? HCNT_W'(sync_i[SY_BL]) : (&acnt | ~sync_i[SY_BL]) ? acnt : acnt + HCNT_W'(1);
    vcnt_n = vs_edge ? VCNT_W'(hs_edge) : (hs_edge & ~&vcnt) ? vcnt + VCNT_W'(1) : vcnt;
    m_h = hs_edge ? hcnt : h_total_o;
    watchdog = vdata_valid_i & ~clr_i & ((&hcnt_n) | (&vcnt_n));
  end
  // previous sync sample only advances on valid data, clear does not disturb it
  always_ff @(posedge VCLK or negedge nVRST_Tx)
    if (!nVRST_Tx) prev_sync <= 4'hF;
    else if (vdata_valid_i) prev_sync <= sync_i;
  // sample/line counters and the latched measurements
  always_ff @(posedge VCLK or negedge nVRST_Tx)
    if (!nVRST_Tx) begin
      hcnt <= '0;
      acnt <= '0;
      vcnt <= '0;
      h_total_o <= '0;
      h_active_o <= '0;
      v_total_o <= '0;
      frame_strobe_o <= 1'b0;
    end else if (clr_i) begin
      hcnt <= '0;
      acnt <= '0;
      vcnt <= '0;
      h_total_o <= '0;
      h_active_o <= '0;
      v_total_o <= '0;
      frame_strobe_o <= 1'b0;
    end else begin
      frame_strobe_o <= vs_edge;
      if (vdata_valid_i) begin
        hcnt <= hcnt_n;
        acnt <= acnt_n;
        vcnt <= vcnt_n;
      end
      if (hs_edge) begin
        h_total_o <= hcnt;
        h_active_o <= acnt;
      end
      if (vs_edge) v_total_o <= vcnt;
    end
  n64adv_vout_timing_monitor_timing_lock_fsm #(
    .HCNT_W(HCNT_W),
    .VCNT_W(VCNT_W),
    .STABLE_FRAMES(STABLE_FRAMES),
    .VTOL(VTOL)
  ) u_lock (
    .VCLK(VCLK),
    .nVRST_Tx(nVRST_Tx),
    .clr(clr_i),
    .vs_edge(vs_edge),
    .watchdog(watchdog),
    .m_h(m_h),
    .m_v(vcnt),
    .timing_stable_o(timing_stable_o),
    .unstable_cnt_o(unstable_cnt_o)
  );
endmodule
